// File: rtl/param_triggered_ts_generator.sv
// Triggered timestamp generator: TS1/TS2 counters with overflow extension, frame sync pulses
// and programmable trigger/injection windows, free-running or armed single-shot.
module param_triggered_ts_generator #(
    parameter int TS1_W      = 10,
    parameter int TS1_OVF_W  = 30,
    parameter int TS2_W      = 7,
    parameter int TS2_OVF_W  = 25,
    parameter int DIV_W      = 8,
    parameter int FRAME_LOG2 = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic                        single_shot,
    input  logic                        arm,
    input  logic [DIV_W-1:0]            tsdiv,
    input  logic [DIV_W-1:0]            ts2div,
    input  logic [DIV_W-1:0]            tsphase,
    input  logic [TS1_W-1:0]            trig_start,
    input  logic [TS1_W-1:0]            trig_stop,
    input  logic [TS1_W-1:0]            inj_start,
    input  logic [TS1_W-1:0]            inj_stop,
    output logic [TS1_W+TS1_OVF_W-1:0]  tsout,
    output logic [TS2_W+TS2_OVF_W-1:0]  ts2out,
    output logic                        sync_reset,
    output logic                        overflow_sync,
    output logic                        trigger,
    output logic                        inj_trigger,
    output logic                        busy
);

    localparam int N_WIN    = 2;
    localparam int WIN_TRIG = 0;
    localparam int WIN_INJ  = 1;

    // ------------------------------------------------------------------
    // Tick dividers
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] div1_reg;
    logic [DIV_W-1:0] div1_next;
    logic [DIV_W-1:0] div2_reg;
    logic [DIV_W-1:0] div2_next;
    logic             tick1;
    logic             tick2;

    // ">=" rather than "==" so a divider lowered below the running count ticks at once
    assign tick1     = (div1_reg >= tsdiv);
    assign tick2     = (div2_reg >= ts2div);
    assign div1_next = tick1 ? '0 : div1_reg + 1'b1;
    assign div2_next = tick2 ? '0 : div2_reg + 1'b1;

    // ------------------------------------------------------------------
    // Timestamp counters
    // ------------------------------------------------------------------
    logic [TS1_W-1:0]     ts1_reg;
    logic [TS1_OVF_W-1:0] ovf1_reg;
    logic [TS2_W-1:0]     ts2_reg;
    logic [TS2_OVF_W-1:0] ovf2_reg;
    logic [TS1_OVF_W-1:0] ovf1_inc;
    logic                 wrap1;
    logic                 wrap2;
    logic                 in_frame;
    logic                 enter_frame;
    logic                 leave_frame;

    assign wrap1       = tick1 && (&ts1_reg);
    assign wrap2       = tick2 && (&ts2_reg);
    assign ovf1_inc    = ovf1_reg + 1'b1;
    assign in_frame    = (ovf1_reg[FRAME_LOG2-1:0] == '0);
    assign enter_frame = wrap1 && (ovf1_inc[FRAME_LOG2-1:0] == '0);
    assign leave_frame = wrap1 && in_frame;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            div1_reg <= '0;
            div2_reg <= '0;
            ts1_reg  <= '0;
            ovf1_reg <= '0;
            ts2_reg  <= '0;
            ovf2_reg <= '0;
        end else if (!enable) begin
            // tsphase sets the TS2 tick phase relative to TS1 once enable rises
            div1_reg <= '0;
            div2_reg <= tsphase;
            ts1_reg  <= '0;
            ovf1_reg <= '0;
            ts2_reg  <= '0;
            ovf2_reg <= '0;
        end else begin
            div1_reg <= div1_next;
            div2_reg <= div2_next;
            if (tick1) begin
                ts1_reg <= ts1_reg + 1'b1;
                if (wrap1) begin
                    ovf1_reg <= ovf1_inc;
                end
            end
            if (tick2) begin
                ts2_reg <= ts2_reg + 1'b1;
                if (wrap2) begin
                    ovf2_reg <= ovf2_reg + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Trigger / injection windows
    // ------------------------------------------------------------------
    logic [TS1_W-1:0] win_start [N_WIN];
    logic [TS1_W-1:0] win_stop  [N_WIN];
    logic [N_WIN-1:0] win_reg;
    logic [N_WIN-1:0] win_next;
    logic [N_WIN-1:0] win_hit_start;
    logic [N_WIN-1:0] win_hit_stop;
    logic             win_eval;
    logic             set_allowed;
    logic             armed_reg;
    logic             armed_next;
    logic             busy_reg;
    logic             busy_next;
    logic             trig_fall;

    assign win_start[WIN_TRIG] = trig_start;
    assign win_stop[WIN_TRIG]  = trig_stop;
    assign win_start[WIN_INJ]  = inj_start;
    assign win_stop[WIN_INJ]   = inj_stop;

    assign win_eval    = tick1 && in_frame;
    assign set_allowed = !single_shot || armed_reg;

    // Compared against the pre-increment ts1, so the output rises as ts1 leaves start
    generate
        for (genvar gi = 0; gi < N_WIN; gi++) begin : g_win
            assign win_hit_start[gi] = (ts1_reg == win_start[gi]);
            assign win_hit_stop[gi]  = (ts1_reg == win_stop[gi]);
            assign win_next[gi] = wrap1                                  ? 1'b0 :
                                  !win_eval                              ? win_reg[gi] :
                                  win_hit_stop[gi]                       ? 1'b0 :
                                  (win_hit_start[gi] && set_allowed)     ? 1'b1 :
                                                                           win_reg[gi];
        end
    endgenerate

    assign trig_fall = win_reg[WIN_TRIG] && !win_next[WIN_TRIG];

    // One arm buys one trigger window; an unused arm expires at the end of its frame
    always_comb begin
        armed_next = armed_reg;
        if (armed_reg && (trig_fall || leave_frame)) begin
            armed_next = 1'b0;
        end else if (arm && single_shot && !busy_reg) begin
            armed_next = 1'b1;
        end
    end

    assign busy_next = armed_next || (|win_next);

    // ------------------------------------------------------------------
    // Registered control outputs
    // ------------------------------------------------------------------
    logic sync_reset_reg;
    logic overflow_sync_reg;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            win_reg           <= '0;
            armed_reg         <= 1'b0;
            busy_reg          <= 1'b0;
            sync_reset_reg    <= 1'b0;
            overflow_sync_reg <= 1'b0;
        end else if (!enable) begin
            win_reg           <= '0;
            armed_reg         <= 1'b0;
            busy_reg          <= 1'b0;
            sync_reset_reg    <= 1'b0;
            overflow_sync_reg <= 1'b0;
        end else begin
            win_reg           <= win_next;
            armed_reg         <= armed_next;
            busy_reg          <= busy_next;
            sync_reset_reg    <= enter_frame;
            overflow_sync_reg <= wrap1;
        end
    end

    assign tsout         = {ovf1_reg, ts1_reg};
    assign ts2out        = {ovf2_reg, ts2_reg};
    assign sync_reset    = sync_reset_reg;
    assign overflow_sync = overflow_sync_reg;
    assign trigger       = win_reg[WIN_TRIG];
    assign inj_trigger   = win_reg[WIN_INJ];
    assign busy          = busy_reg;

endmodule

// File: tb/tb_param_triggered_ts_generator.sv
// Randomised self-checking bench for param_triggered_ts_generator against an arithmetic model
// that derives every output from the number of clocks since enable rose.
module tb_param_triggered_ts_generator;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        single_shot = 1'b0;
    logic        arm = 1'b0;
    logic [7:0]  tsdiv = '0;
    logic [7:0]  ts2div = '0;
    logic [7:0]  tsphase = '0;
    logic [9:0]  trig_start = '0;
    logic [9:0]  trig_stop = '0;
    logic [9:0]  inj_start = '0;
    logic [9:0]  inj_stop = '0;
    logic [39:0] tsout;
    logic [31:0] ts2out;
    logic        sync_reset;
    logic        overflow_sync;
    logic        trigger;
    logic        inj_trigger;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    param_triggered_ts_generator dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .enable        (enable),
        .single_shot   (single_shot),
        .arm           (arm),
        .tsdiv         (tsdiv),
        .ts2div        (ts2div),
        .tsphase       (tsphase),
        .trig_start    (trig_start),
        .trig_stop     (trig_stop),
        .inj_start     (inj_start),
        .inj_stop      (inj_stop),
        .tsout         (tsout),
        .ts2out        (ts2out),
        .sync_reset    (sync_reset),
        .overflow_sync (overflow_sync),
        .trigger       (trigger),
        .inj_trigger   (inj_trigger),
        .busy          (busy)
    );

    typedef struct packed {
        logic [39:0] ts;
        logic [31:0] ts2;
        logic        sync;
        logic        ovfs;
        logic        trig;
        logic        inj;
        logic        busy;
    } obs_t;

    function automatic obs_t observe();
        obs_t o;
        o = {tsout, ts2out, sync_reset, overflow_sync, trigger, inj_trigger, busy};
        return o;
    endfunction

    // Window is open at ts1=t when start has been passed and stop has not been passed after it
    function automatic bit win_open(int t, int s, int p);
        return (s != p) && (s < t) && !((s < p) && (p < t));
    endfunction

    // Number of ts1 values per frame during which the window is visibly open
    function automatic int win_len(int s, int p);
        int e;
        if (s == p || s >= 1023) return 0;
        e = (p > s) ? p : 1023;
        return e - s;
    endfunction

    // Expected outputs after k enabled clocks with constant configuration
    function automatic obs_t model(int k, int d1, int d2, int ph, int s1, int p1,
                                   int s2, int p2, int only_frame);
        obs_t e;
        int n1, n2, t1, o1, t2, o2, first;
        bit infr;
        n1 = k / (d1 + 1);
        t1 = n1 % 1024;
        o1 = n1 / 1024;
        first = (ph >= d2) ? 1 : d2 - ph + 1;
        n2 = (k < first) ? 0 : 1 + (k - first) / (d2 + 1);
        t2 = n2 % 128;
        o2 = n2 / 128;
        e.ts   = {o1[29:0], t1[9:0]};
        e.ts2  = {o2[24:0], t2[6:0]};
        e.ovfs = (k > 0) && (k % (d1 + 1) == 0) && (t1 == 0);
        e.sync = e.ovfs && (o1 % 4 == 0);
        infr   = (o1 % 4 == 0) && ((only_frame < 0) || (o1 == only_frame));
        e.trig = infr && win_open(t1, s1, p1);
        e.inj  = infr && win_open(t1, s2, p2);
        e.busy = e.trig || e.inj;
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_run(int d1, int d2, int ph, int s1, int p1, int s2, int p2, bit ss);
        enable      = 1'b0;
        arm         = 1'b0;
        single_shot = ss;
        tsdiv       = d1[7:0];
        ts2div      = d2[7:0];
        tsphase     = ph[7:0];
        trig_start  = s1[9:0];
        trig_stop   = p1[9:0];
        inj_start   = s2[9:0];
        inj_stop    = p2[9:0];
        tick();
        tick();
        enable = 1'b1;
    endtask

    task automatic test_reset();
        obs_t e, g;
        bit bad = 0;
        reset_n = 1'b0;
        repeat (3) tick();
        checks++;
        if (observe() !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_init obs %h exp 0", observe());
        end
        reset_n = 1'b1;
        start_run(0, 1, 0, 10, 20, 5, 30, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            tick();
            e = model(k, 0, 1, 0, 10, 20, 5, 30, -1);
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_prerun k=%0d obs %h exp %h", k, g, e);
                bad = 1;
                break;
            end
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if (observe() !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_midrun obs %h exp 0", observe());
        end
        reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            e = model(k, 0, 1, 0, 10, 20, 5, 30, -1);
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL reset_restart k=%0d obs %h exp %h", k, g, e);
                break;
            end
        end
        $display("test_reset done bad_prerun=%0d errors=%0d", bad, errors);
    endtask

    task automatic test_divider();
        obs_t e, g;
        start_run(3, 3, 2, 7, 7, 9, 9, 1'b0);
        for (int k = 1; k <= 600; k++) begin
            tick();
            e = model(k, 3, 3, 2, 7, 7, 9, 9, -1);
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL divider k=%0d obs %h exp %h", k, g, e);
                break;
            end
            if (k == 3 || k == 4) begin
                checks++;
                if (tsout !== ((k == 4) ? 40'd1 : 40'd0)) begin
                    errors++;
                    $display("FAIL ts1_first_tick k=%0d tsout %0d", k, tsout);
                end
            end
            if (k == 1 || k == 2) begin
                checks++;
                if (ts2out !== ((k == 2) ? 32'd1 : 32'd0)) begin
                    errors++;
                    $display("FAIL ts2_phase k=%0d ts2out %0d", k, ts2out);
                end
            end
            if (k == 510) begin
                checks++;
                if (ts2out !== 32'h80) begin
                    errors++;
                    $display("FAIL ts2_wrap ts2out %h exp 80", ts2out);
                end
            end
        end
        $display("test_divider done errors=%0d", errors);
    endtask

    task automatic test_tsdiv_change();
        start_run(7, 0, 0, 3, 3, 3, 3, 1'b0);
        repeat (5) tick();
        checks++;
        if (tsout !== 40'd0) begin
            errors++;
            $display("FAIL tsdiv_pre tsout %0d exp 0", tsout);
        end
        tsdiv = 8'd2;
        tick();
        checks++;
        if (tsout !== 40'd1) begin
            errors++;
            $display("FAIL tsdiv_lowered tsout %0d exp 1", tsout);
        end
        repeat (3) tick();
        checks++;
        if (tsout !== 40'd2) begin
            errors++;
            $display("FAIL tsdiv_period tsout %0d exp 2", tsout);
        end
        $display("test_tsdiv_change done errors=%0d", errors);
    endtask

    task automatic test_continuous(int d1, int s1, int p1, int s2, int p2);
        obs_t e, g;
        int d2, ph, n;
        int cnt_t = 0, cnt_i = 0, cnt_s = 0;
        bit bad = 0;
        d2 = $urandom_range(0, 5);
        ph = $urandom_range(0, 7);
        start_run(d1, d2, ph, s1, p1, s2, p2, 1'b0);
        n = (4 * 1024 + 1100) * (d1 + 1);
        for (int k = 1; k <= n; k++) begin
            arm = ($urandom_range(0, 31) == 0);
            tick();
            e = model(k, d1, d2, ph, s1, p1, s2, p2, -1);
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL continuous k=%0d obs %h exp %h", k, g, e);
                bad = 1;
                break;
            end
            if (trigger && tsout[39:10] == 30'd0) cnt_t++;
            if (inj_trigger && tsout[39:10] == 30'd0) cnt_i++;
            if (sync_reset) cnt_s++;
        end
        arm = 1'b0;
        if (!bad) begin
            checks++;
            if (cnt_t !== win_len(s1, p1) * (d1 + 1)) begin
                errors++;
                $display("FAIL trig_len got %0d exp %0d", cnt_t, win_len(s1, p1) * (d1 + 1));
            end
            checks++;
            if (cnt_i !== win_len(s2, p2) * (d1 + 1)) begin
                errors++;
                $display("FAIL inj_len got %0d exp %0d", cnt_i, win_len(s2, p2) * (d1 + 1));
            end
            checks++;
            if (cnt_s !== 1) begin
                errors++;
                $display("FAIL sync_count got %0d exp 1", cnt_s);
            end
        end
        $display("test_continuous tsdiv=%0d trig %0d/%0d inj %0d/%0d errors=%0d",
                 d1, s1, p1, s2, p2, errors);
    endtask

    task automatic test_wrap_window(int s1, int p1);
        obs_t e, g;
        int cnt_t = 0;
        bit bad = 0;
        start_run(0, 0, 0, s1, p1, 4, 4, 1'b0);
        for (int k = 1; k <= 1100; k++) begin
            tick();
            e = model(k, 0, 0, 0, s1, p1, 4, 4, -1);
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL wrap_window k=%0d obs %h exp %h", k, g, e);
                bad = 1;
                break;
            end
            if (trigger) cnt_t++;
        end
        if (!bad) begin
            checks++;
            if (cnt_t !== win_len(s1, p1)) begin
                errors++;
                $display("FAIL wrap_len got %0d exp %0d", cnt_t, win_len(s1, p1));
            end
        end
        $display("test_wrap_window trig %0d/%0d high=%0d errors=%0d", s1, p1, cnt_t, errors);
    endtask

    task automatic test_single_shot();
        obs_t e, g;
        int s1, p1, k_arm, t1, o1;
        int cnt_t = 0;
        bit bad = 0;
        s1 = $urandom_range(0, 900);
        p1 = s1 + $urandom_range(1, 100);
        k_arm = 1024 + $urandom_range(10, 500);
        start_run(0, 0, 0, s1, p1, 9, 9, 1'b1);
        for (int k = 1; k <= 8 * 1024 + 1100; k++) begin
            arm = (k == k_arm) || (k == 2500);
            tick();
            t1 = k % 1024;
            o1 = k / 1024;
            e = model(k, 0, 0, 0, s1, p1, 9, 9, 4);
            e.busy = (k >= k_arm) && ((o1 < 4) || ((o1 == 4) && (t1 <= p1)));
            g = observe();
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL single_shot k=%0d obs %h exp %h", k, g, e);
                bad = 1;
                break;
            end
            if (trigger) cnt_t++;
        end
        arm = 1'b0;
        if (!bad) begin
            checks++;
            if (cnt_t !== p1 - s1) begin
                errors++;
                $display("FAIL single_shot_len got %0d exp %0d", cnt_t, p1 - s1);
            end
        end
        $display("test_single_shot trig %0d/%0d arm@%0d errors=%0d", s1, p1, k_arm, errors);
    endtask

    initial begin
        int rs, rp;
        test_reset();
        test_divider();
        test_tsdiv_change();
        test_continuous(0, 200, 208, 0, 16);
        rs = $urandom_range(0, 1023);
        rp = $urandom_range(0, 1023);
        test_continuous(1, rs, rp, $urandom_range(0, 1023), $urandom_range(0, 1023));
        test_wrap_window(1020, 5);
        rs = $urandom_range(0, 1023);
        test_wrap_window(rs, rs);
        test_single_shot();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
